// File: rtl/l2_ddr_drain.sv
// l2_ddr_drain: moves lines from L2 BRAM port B into fixed-length DDR write bursts.
// The L1 side reads the consumed-line pointer back for its full/empty logic.
module l2_ddr_drain #(
  parameter int                    BURST_LEN  = 8,
  parameter int                    DDR_ADDR_W = 28,
  parameter logic [DDR_ADDR_W-1:0] DDR_BASE   = '0
) (
  input  logic                  clk_166M66,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [9:0]            i_l2_wr_ptr,
  output logic [9:0]            o_l2_rd_ptr,
  output logic                  o_bram_enb,
  output logic [8:0]            o_bram_addrb,
  input  logic [127:0]          i_bram_doutb,
  output logic                  o_ddr_cmd_valid,
  input  logic                  i_ddr_cmd_ready,
  output logic [DDR_ADDR_W-1:0] o_ddr_cmd_addr,
  output logic                  o_ddr_wdata_valid,
  input  logic                  i_ddr_wdata_ready,
  output logic [127:0]          o_ddr_wdata,
  output logic                  o_ddr_wdata_last,
  output logic                  o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  localparam logic [6:0]            BL_CNT    = 7'(BURST_LEN);
  localparam logic [6:0]            LAST_BEAT = 7'(BURST_LEN - 1);
  localparam logic [9:0]            PTR_STEP  = 10'(BURST_LEN);
  localparam logic [DDR_ADDR_W-1:0] ADDR_STEP = DDR_ADDR_W'(BURST_LEN * 16);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [9:0]              r_rdPtr;
  logic [DDR_ADDR_W-1:0]   r_ddrAddr;
  logic [8:0]              r_rdAddr;
  logic [6:0]              r_issued;
  logic [6:0]              r_beat;
  logic                    r_inflight;
  logic [127:0]            r_fifo [2];
  logic                    r_wrIdx;
  logic                    r_rdIdx;
  logic [1:0]              r_count;

  logic [9:0]              w_diff;
  logic [9:0]              w_avail;
  logic                    w_start;
  logic                    w_valid;
  logic                    w_last;
  logic                    w_pop;
  logic                    w_push;
  logic [2:0]              w_occ;
  logic                    w_enb;

  // Fill level is clamped to 512 so a bogus write pointer can never over-read.
  assign w_diff  = i_l2_wr_ptr - r_rdPtr;
  assign w_avail = (w_diff > 10'd512) ? 10'd512 : w_diff;
  assign w_start = i_enable && (w_avail >= PTR_STEP);

  // A beat is offered only in DATA, so nothing precedes the command handshake.
  assign w_valid = (r_state == S_DATA) && (r_count != 2'd0);
  assign w_last  = (r_beat == LAST_BEAT);
  assign w_pop   = w_valid && i_ddr_wdata_ready;
  assign w_push  = r_inflight;

  // Occupancy counts the pop of this cycle so a streaming burst has no bubbles.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_enb = ((r_state == S_CMD) || (r_state == S_DATA)) &&
                 (r_issued < BL_CNT) && (w_occ < 3'd2);

  // Next-state selection for the burst sequencer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_nextState = S_CMD;
      S_CMD:  if (i_ddr_cmd_ready) w_nextState = S_DATA;
      S_DATA: if (w_pop && w_last) w_nextState = S_DONE;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_166M66 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Per-burst read address, issue count and beat index.
  always_ff @(posedge clk_166M66 or negedge rst_n) begin
    if (!rst_n) begin
      r_rdAddr   <= '0;
      r_issued   <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_enb;
      if ((r_state == S_IDLE) && w_start) begin
        r_rdAddr <= r_rdPtr[8:0];
        r_issued <= '0;
        r_beat   <= '0;
      end
      if (w_enb) begin
        r_rdAddr <= r_rdAddr + 9'd1;
        r_issued <= r_issued + 7'd1;
      end
      if (w_pop) r_beat <= r_beat + 7'd1;
    end
  end

  // Two-entry output FIFO absorbing the BRAM read latency.
  always_ff @(posedge clk_166M66 or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wrIdx   <= 1'b0;
      r_rdIdx   <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrIdx] <= i_bram_doutb;
        r_wrIdx         <= ~r_wrIdx;
      end
      if (w_pop) r_rdIdx <= ~r_rdIdx;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Consumed pointer and DDR address advance only once the whole burst is accepted.
  always_ff @(posedge clk_166M66 or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr   <= '0;
      r_ddrAddr <= DDR_BASE;
    end else if (r_state == S_DONE) begin
      r_rdPtr   <= r_rdPtr + PTR_STEP;
      r_ddrAddr <= r_ddrAddr + ADDR_STEP;
    end
  end

  assign o_l2_rd_ptr       = r_rdPtr;
  assign o_bram_enb        = w_enb;
  assign o_bram_addrb      = r_rdAddr;
  assign o_ddr_cmd_valid   = (r_state == S_CMD);
  assign o_ddr_cmd_addr    = r_ddrAddr;
  assign o_ddr_wdata_valid = w_valid;
  assign o_ddr_wdata       = r_fifo[r_rdIdx];
  assign o_ddr_wdata_last  = w_last;
  assign o_busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_l2_ddr_drain.sv
// Testbench for l2_ddr_drain: BRAM model, scoreboard of expected commands and beats.
module tb_l2_ddr_drain;

  logic         clk_166M66 = 1'b0;
  logic         rst_n;
  logic         i_enable;
  logic [9:0]   i_l2_wr_ptr;
  logic [9:0]   o_l2_rd_ptr;
  logic         o_bram_enb;
  logic [8:0]   o_bram_addrb;
  logic [127:0] i_bram_doutb;
  logic         o_ddr_cmd_valid;
  logic         i_ddr_cmd_ready;
  logic [27:0]  o_ddr_cmd_addr;
  logic         o_ddr_wdata_valid;
  logic         i_ddr_wdata_ready;
  logic [127:0] o_ddr_wdata;
  logic         o_ddr_wdata_last;
  logic         o_busy;

  int checks = 0;
  int passes = 0;

  logic [27:0]  cmdQ [$];
  logic [128:0] beatQ [$];
  logic [9:0]   nextLine;
  logic [27:0]  nextAddr;

  int           dataReadyMode = 0;
  int           beatsAccepted = 0;
  int           beatsSincePtr = 0;
  int           outstanding = 0;
  int           maxOutstanding = 0;
  int           burstStart = 0;
  int           burstSpan = 0;
  int           cyc = 0;

  l2_ddr_drain #(
    .BURST_LEN (8),
    .DDR_ADDR_W(28),
    .DDR_BASE  (28'h0)
  ) dut (
    .clk_166M66       (clk_166M66),
    .rst_n            (rst_n),
    .i_enable         (i_enable),
    .i_l2_wr_ptr      (i_l2_wr_ptr),
    .o_l2_rd_ptr      (o_l2_rd_ptr),
    .o_bram_enb       (o_bram_enb),
    .o_bram_addrb     (o_bram_addrb),
    .i_bram_doutb     (i_bram_doutb),
    .o_ddr_cmd_valid  (o_ddr_cmd_valid),
    .i_ddr_cmd_ready  (i_ddr_cmd_ready),
    .o_ddr_cmd_addr   (o_ddr_cmd_addr),
    .o_ddr_wdata_valid(o_ddr_wdata_valid),
    .i_ddr_wdata_ready(i_ddr_wdata_ready),
    .o_ddr_wdata      (o_ddr_wdata),
    .o_ddr_wdata_last (o_ddr_wdata_last),
    .o_busy           (o_busy)
  );

  // Free-running ~166 MHz clock.
  always #3 clk_166M66 = ~clk_166M66;

  // Every BRAM line holds a distinct pattern derived from its index.
  function automatic logic [127:0] lineData(input int idx);
    logic [31:0] v;
    v = 32'(idx);
    return {32'hDA7A_0000 ^ v, v * 32'd7 + 32'h1111, ~v, 32'h5EED_0000 + v};
  endfunction

  // BRAM port B model with one cycle of read latency.
  always @(posedge clk_166M66) begin
    if (o_bram_enb) i_bram_doutb <= lineData(int'(o_bram_addrb));
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [128:0] actual, input logic [128:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
  endtask

  // Drives the L1-side pointer and the enable.
  task automatic applyStimulus(input logic [9:0] wrPtr, input logic en);
    i_l2_wr_ptr = wrPtr;
    i_enable    = en;
  endtask

  // Pushes the command address and the eight beats the next burst must produce.
  task automatic queueBurst();
    for (int k = 0; k < 8; k++) begin
      beatQ.push_back({(k == 7), lineData((int'(nextLine[8:0]) + k) % 512)});
    end
    cmdQ.push_back(nextAddr);
    nextLine = nextLine + 10'd8;
    nextAddr = nextAddr + 28'h80;
  endtask

  // Waits a bounded number of cycles for the consumed pointer to reach a value.
  task automatic waitPtr(input logic [9:0] expPtr, input int bound);
    int n;
    n = 0;
    while ((o_l2_rd_ptr !== expPtr) && (n < bound)) begin
      @(posedge clk_166M66); #1;
      n++;
    end
    checkOutput("rdPtr", o_l2_rd_ptr, expPtr);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rdPtr"}, o_l2_rd_ptr, 0);
    checkOutput({tag, "_valids"}, {o_ddr_cmd_valid, o_ddr_wdata_valid, o_bram_enb, o_busy}, 0);
    checkOutput({tag, "_cmdAddr"}, o_ddr_cmd_addr, 28'h0);
  endtask

  // Write-data ready: held high, or toggled randomly when requested.
  initial begin
    i_ddr_wdata_ready = 1'b1;
    forever begin
      @(posedge clk_166M66); #1;
      if (dataReadyMode != 0) i_ddr_wdata_ready = 1'($urandom_range(0, 1));
      else                    i_ddr_wdata_ready = 1'b1;
    end
  end

  // Monitor: handshake scoreboard, stall stability, read-ahead bound, burst accounting.
  initial begin
    logic         prevDataStall;
    logic         prevCmdStall;
    logic [128:0] prevBeat;
    logic [27:0]  prevAddr;
    logic [9:0]   prevPtr;
    prevDataStall = 1'b0;
    prevCmdStall  = 1'b0;
    prevBeat      = '0;
    prevAddr      = '0;
    prevPtr       = '0;
    forever begin
      @(negedge clk_166M66);
      cyc++;
      if (!rst_n) begin
        prevDataStall = 1'b0;
        prevCmdStall  = 1'b0;
        beatsSincePtr = 0;
        outstanding   = 0;
        prevPtr       = o_l2_rd_ptr;
      end else begin
        if (prevDataStall) begin
          checkOutput("wdataValidHold", o_ddr_wdata_valid, 1);
          checkOutput("wdataHold", {o_ddr_wdata_last, o_ddr_wdata}, prevBeat);
        end
        if (prevCmdStall) begin
          checkOutput("cmdHold", {o_ddr_cmd_valid, o_ddr_cmd_addr}, {1'b1, prevAddr});
        end
        if (o_ddr_cmd_valid) checkOutput("beatBeforeCmd", o_ddr_wdata_valid, 0);
        if (o_bram_enb) outstanding++;
        if (o_ddr_cmd_valid && i_ddr_cmd_ready) begin
          if (cmdQ.size() == 0) checkOutput("cmdUnexpected", 1, 0);
          else                  checkOutput("cmdAddr", o_ddr_cmd_addr, cmdQ.pop_front());
        end
        if (o_ddr_wdata_valid && i_ddr_wdata_ready) begin
          outstanding--;
          if (beatsSincePtr == 0) burstStart = cyc;
          if (o_ddr_wdata_last) burstSpan = cyc - burstStart;
          beatsSincePtr++;
          beatsAccepted++;
          if (beatQ.size() == 0) checkOutput("beatUnexpected", 1, 0);
          else                   checkOutput("beat", {o_ddr_wdata_last, o_ddr_wdata}, beatQ.pop_front());
        end
        if (outstanding > maxOutstanding) maxOutstanding = outstanding;
        if (o_l2_rd_ptr !== prevPtr) begin
          checkOutput("beatsPerBurst", beatsSincePtr, 8);
          beatsSincePtr = 0;
          prevPtr       = o_l2_rd_ptr;
        end
        prevDataStall = o_ddr_wdata_valid && !i_ddr_wdata_ready;
        prevBeat      = {o_ddr_wdata_last, o_ddr_wdata};
        prevCmdStall  = o_ddr_cmd_valid && !i_ddr_cmd_ready;
        prevAddr      = o_ddr_cmd_addr;
      end
    end
  end

  // Directed sequence of scenarios.
  initial begin
    int n;
    int bad;
    int early;
    int cmdSeen;
    int base;
    rst_n           = 1'b0;
    i_ddr_cmd_ready = 1'b1;
    applyStimulus(10'd0, 1'b0);
    nextLine = '0;
    nextAddr = '0;
    repeat (3) @(posedge clk_166M66);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Single burst from line 0 with both readies high.
    queueBurst();
    applyStimulus(10'd8, 1'b1);
    waitPtr(10'd8, 100);
    checkOutput("burstSpan", burstSpan, 7);
    checkOutput("beatsDrained", beatQ.size(), 0);

    // One line short of a burst: nothing may start.
    applyStimulus(10'd15, 1'b1);
    bad = 0;
    repeat (30) begin
      @(posedge clk_166M66); #1;
      if (o_ddr_cmd_valid || o_busy) bad++;
    end
    checkOutput("noStartBelowBurst", bad, 0);
    queueBurst();
    applyStimulus(10'd16, 1'b1);
    n = 0;
    while (!o_ddr_cmd_valid && n < 10) begin
      @(posedge clk_166M66); #1;
      n++;
    end
    checkOutput("startLatency", (n >= 1 && n <= 2), 1);
    waitPtr(10'd16, 100);

    // Random write-data backpressure.
    dataReadyMode = 1;
    queueBurst();
    applyStimulus(10'd24, 1'b1);
    waitPtr(10'd24, 500);
    dataReadyMode = 0;
    checkOutput("fifoBound", (maxOutstanding <= 2), 1);

    // Command stalled for 20 cycles.
    i_ddr_cmd_ready = 1'b0;
    queueBurst();
    applyStimulus(10'd32, 1'b1);
    early   = 0;
    cmdSeen = 0;
    repeat (20) begin
      @(posedge clk_166M66); #1;
      if (o_ddr_wdata_valid) early++;
      if (o_ddr_cmd_valid) cmdSeen++;
    end
    checkOutput("noBeatWhileCmdStalled", early, 0);
    checkOutput("cmdHeldValid", cmdSeen, 20);
    i_ddr_cmd_ready = 1'b1;
    waitPtr(10'd32, 100);

    // Run to and through the line-address wrap.
    for (int b = 0; b < 62; b++) queueBurst();
    applyStimulus(10'h210, 1'b1);
    waitPtr(10'h210, 3000);
    checkOutput("wrapBit", o_l2_rd_ptr[9], 1);
    checkOutput("cmdDrained", cmdQ.size(), 0);

    // Enable dropped mid-burst: the burst finishes, no further burst starts.
    queueBurst();
    applyStimulus(10'h220, 1'b1);
    n = 0;
    while (!o_ddr_cmd_valid && n < 10) begin
      @(posedge clk_166M66); #1;
      n++;
    end
    checkOutput("cmdSeenBeforeDisable", o_ddr_cmd_valid, 1);
    applyStimulus(10'h220, 1'b0);
    waitPtr(10'h218, 100);
    bad = 0;
    repeat (20) begin
      @(posedge clk_166M66); #1;
      if (o_busy || o_ddr_cmd_valid) bad++;
    end
    checkOutput("idleWhenDisabled", bad, 0);
    checkOutput("ptrHeldDisabled", o_l2_rd_ptr, 10'h218);

    // Reset after the third accepted beat of a burst.
    queueBurst();
    base = beatsAccepted;
    applyStimulus(10'h220, 1'b1);
    n = 0;
    while ((beatsAccepted < base + 3) && n < 100) begin
      @(posedge clk_166M66); #1;
      n++;
    end
    checkOutput("thirdBeatReached", (beatsAccepted >= base + 3), 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midBurstReset");
    cmdQ.delete();
    beatQ.delete();
    nextLine = '0;
    nextAddr = '0;
    applyStimulus(10'd8, 1'b1);
    @(posedge clk_166M66); #1;
    queueBurst();
    rst_n = 1'b1;
    waitPtr(10'd8, 100);
    checkOutput("postResetDrained", beatQ.size(), 0);
    checkOutput("fifoBoundFinal", (maxOutstanding <= 2), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
